// File: rtl/bel_bfly_seq_if.sv
// Bus bundle between the radix-2 butterfly sequencer and its data RAM,
// twiddle ROM and combinational complex MAC.
interface bel_bfly_seq_if #(
  parameter int LOG2N = 6
);
  logic                    start_i;
  logic                    busy_o;
  logic                    done_o;
  logic [LOG2N-1:0]        mem_addr_o;
  logic                    mem_we_o;
  logic signed [15:0]      mem_wdata_re_o, mem_wdata_im_o;
  logic signed [15:0]      mem_rdata_re_i, mem_rdata_im_i;
  logic [LOG2N-2:0]        tw_addr_o;
  logic signed [15:0]      tw_re_i, tw_im_i;
  logic signed [15:0]      cmac_a_re_o, cmac_a_im_o;
  logic signed [15:0]      cmac_b_re_o, cmac_b_im_o;
  logic signed [15:0]      cmac_c_re_o, cmac_c_im_o;
  logic signed [15:0]      cmac_x_re_i, cmac_x_im_i;

  modport master (
    input  start_i, mem_rdata_re_i, mem_rdata_im_i, tw_re_i, tw_im_i,
           cmac_x_re_i, cmac_x_im_i,
    output busy_o, done_o, mem_addr_o, mem_we_o, mem_wdata_re_o, mem_wdata_im_o,
           tw_addr_o, cmac_a_re_o, cmac_a_im_o, cmac_b_re_o, cmac_b_im_o,
           cmac_c_re_o, cmac_c_im_o
  );

  modport slave (
    output start_i, mem_rdata_re_i, mem_rdata_im_i, tw_re_i, tw_im_i,
           cmac_x_re_i, cmac_x_im_i,
    input  busy_o, done_o, mem_addr_o, mem_we_o, mem_wdata_re_o, mem_wdata_im_o,
           tw_addr_o, cmac_a_re_o, cmac_a_im_o, cmac_b_re_o, cmac_b_im_o,
           cmac_c_re_o, cmac_c_im_o
  );
endinterface

// File: rtl/bel_bfly_seq.sv
// Radix-2 DIT in-place butterfly sequencer: walks all stages/butterflies,
// feeds the complex MAC and writes x = a + b*w and 2a - x back in place.
module bel_bfly_seq #(
  parameter int LOG2N = 6
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  bel_bfly_seq_if.master bus
);
  localparam int              DATA_W = 16;
  localparam int              BW     = LOG2N - 1;
  localparam logic [3:0]      LAST_S = 4'(LOG2N - 1);
  localparam logic [BW-1:0]   LAST_B = '1;
  localparam logic [LOG2N-1:0] ONE_N = {{(LOG2N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, LAT, WR_A, WR_B} state_t;

  state_t        state, state_nxt;
  logic [3:0]    stg, stg_nxt;
  logic [BW-1:0] bfly, bfly_nxt;
  logic          done_r, done_nxt;

  logic signed [DATA_W-1:0] a_re_p1, a_im_p1;
  logic signed [DATA_W-1:0] b_re_p2, b_im_p2, c_re_p2, c_im_p2;

  logic [LOG2N-1:0] b_ext, half, k, idx_i, idx_j;
  logic [3:0]       tw_sh;
  logic [BW-1:0]    tw_idx;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [DATA_W+1:0] v);
    if (v > 18'sd32767)       return 16'sh7fff;
    else if (v < -18'sd32768) return 16'sh8000;
    else                      return v[DATA_W-1:0];
  endfunction

  // Lower leg a - b*w expressed as 2a - x so only one multiplier is needed.
  function automatic logic signed [DATA_W-1:0] lower_leg(input logic signed [DATA_W-1:0] a,
                                                          input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W+1:0] a18, x18;
    a18 = 18'(a);
    x18 = 18'(x);
    return sat16((a18 <<< 1) - x18);
  endfunction

  always_comb begin
    b_ext  = {1'b0, bfly};
    half   = ONE_N << stg;
    k      = b_ext & (half - ONE_N);
    idx_i  = ((b_ext >> stg) << (stg + 4'd1)) | k;
    idx_j  = idx_i | half;
    tw_sh  = LAST_S - stg;
    tw_idx = k[BW-1:0] << tw_sh;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      stg    <= '0;
      bfly   <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      stg    <= stg_nxt;
      bfly   <= bfly_nxt;
      done_r <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stg_nxt   = stg;
    bfly_nxt  = bfly;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (bus.start_i) begin
        state_nxt = RD_A;
        stg_nxt   = '0;
        bfly_nxt  = '0;
      end
      RD_A: state_nxt = RD_B;
      RD_B: state_nxt = LAT;
      LAT:  state_nxt = WR_A;
      WR_A: state_nxt = WR_B;
      WR_B: begin
        if (bfly != LAST_B) begin
          bfly_nxt  = bfly + BW'(1);
          state_nxt = RD_A;
        end else if (stg != LAST_S) begin
          bfly_nxt  = '0;
          stg_nxt   = stg + 4'd1;
          state_nxt = RD_A;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 1: A arrives one cycle after RD_A; stage 2: B and W one cycle after RD_B.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      a_re_p1 <= '0;
      a_im_p1 <= '0;
      b_re_p2 <= '0;
      b_im_p2 <= '0;
      c_re_p2 <= '0;
      c_im_p2 <= '0;
    end else if (state == RD_B) begin
      a_re_p1 <= bus.mem_rdata_re_i;
      a_im_p1 <= bus.mem_rdata_im_i;
    end else if (state == LAT) begin
      b_re_p2 <= bus.mem_rdata_re_i;
      b_im_p2 <= bus.mem_rdata_im_i;
      c_re_p2 <= bus.tw_re_i;
      c_im_p2 <= bus.tw_im_i;
    end
  end

  always_comb begin
    bus.mem_addr_o     = '0;
    bus.mem_we_o       = 1'b0;
    bus.mem_wdata_re_o = '0;
    bus.mem_wdata_im_o = '0;
    bus.tw_addr_o      = '0;
    case (state)
      RD_A: bus.mem_addr_o = idx_i;
      RD_B: begin
        bus.mem_addr_o = idx_j;
        bus.tw_addr_o  = tw_idx;
      end
      LAT:  bus.mem_addr_o = idx_j;
      WR_A: begin
        bus.mem_addr_o     = idx_i;
        bus.mem_we_o       = 1'b1;
        bus.mem_wdata_re_o = bus.cmac_x_re_i;
        bus.mem_wdata_im_o = bus.cmac_x_im_i;
      end
      WR_B: begin
        bus.mem_addr_o     = idx_j;
        bus.mem_we_o       = 1'b1;
        bus.mem_wdata_re_o = lower_leg(a_re_p1, bus.cmac_x_re_i);
        bus.mem_wdata_im_o = lower_leg(a_im_p1, bus.cmac_x_im_i);
      end
      default: ;
    endcase
  end

  assign bus.busy_o      = (state != IDLE);
  assign bus.done_o      = done_r;
  assign bus.cmac_a_re_o = a_re_p1;
  assign bus.cmac_a_im_o = a_im_p1;
  assign bus.cmac_b_re_o = b_re_p2;
  assign bus.cmac_b_im_o = b_im_p2;
  assign bus.cmac_c_re_o = c_re_p2;
  assign bus.cmac_c_im_o = c_im_p2;
endmodule

// File: doc/bel_bfly_seq.md
Name: bel_bfly_seq

Overview:
Radix-2 DIT in-place butterfly sequencer for the belfft core. It walks every stage and butterfly of an N-point FFT and reads operand pairs from a single-port data RAM and twiddles from a sync ROM. It drives the combinational complex MAC (x = a + b*w), derives the lower leg as 2a - x, and writes both results back in place. It sits directly upstream of the complex MAC and owns all of its operand registers.

Parameters:
LOG2N, 6, log2 of FFT length N (N = 2^LOG2N; legal range 2..10)

Ports:
clk_i  in  1  clock, all state on rising edge
rstn_i  in  1  asynchronous active-low reset
start_i  in  1  start FFT pass; sampled only in IDLE
busy_o  out  1  high from first RD_A through last WR_B
done_o  out  1  one-cycle pulse after final write
mem_addr_o  out  LOG2N  data RAM address
mem_we_o  out  1  data RAM write enable
mem_wdata_re_o  out  16  write data, real
mem_wdata_im_o  out  16  write data, imag
mem_rdata_re_i  in  16  RAM read data, real; valid 1 cycle after address
mem_rdata_im_i  in  16  RAM read data, imag
tw_addr_o  out  LOG2N-1  twiddle ROM address
tw_re_i  in  16  twiddle real, Q1.15; valid 1 cycle after tw_addr_o
tw_im_i  in  16  twiddle imag, Q1.15, W = exp(-j2*pi*k/N)
cmac_a_re_o, cmac_a_im_o  out  16 each  registered A operand
cmac_b_re_o, cmac_b_im_o  out  16 each  registered B operand
cmac_c_re_o, cmac_c_im_o  out  16 each  registered twiddle
cmac_x_re_i, cmac_x_im_i  in  16 each  MAC result a + b*w, rounded Q1.15

Behaviour:
- Reset (async, rstn_i low): FSM to IDLE. Stage, butterfly and operand registers clear to 0. All outputs 0 while reset is asserted, including mem_we_o. Reset mid-pass abandons the pass; RAM contents are then undefined. No write is issued after reset deasserts until a new start.
- States: IDLE, RD_A, RD_B, LAT, WR_A, WR_B.
- IDLE: start_i=1 goes to RD_A with stage s=0 and butterfly b=0. start_i is ignored in every other state.
- Index math, per stage s (0..LOG2N-1) and butterfly b (0..N/2-1):
  - half = 2^s, k = b mod half
  - i = ((b >> s) << (s+1)) | k; j = i + half
  - twiddle index t = k << (LOG2N-1-s)
- RD_A: mem_addr_o = i. Next state RD_B.
- RD_B: mem_addr_o = j, tw_addr_o = t. Capture A (mem_rdata) into the cmac_a registers at the clock edge. Next state LAT.
- LAT: capture B (mem_rdata) into cmac_b and tw_re_i/tw_im_i into cmac_c at the clock edge. Next state WR_A.
- WR_A: mem_addr_o = i, mem_we_o = 1, mem_wdata = cmac_x_i (passed through, no further rounding). Next state WR_B.
- WR_B: mem_addr_o = j, mem_we_o = 1, mem_wdata = sat16(2*a - x) per component.
  - Computed in 18-bit signed, then saturated: >32767 gives 32767, < -32768 gives -32768.
  - A, B and W stay registered, so cmac_x_i is still valid in this state.
- After WR_B:
  - b < N/2-1: b++ and go to RD_A.
  - b = N/2-1 and s < LOG2N-1: b = 0, s++, go to RD_A.
  - Otherwise go to IDLE with done_o = 1 for exactly that one cycle.
- Throughput: 5 cycles per butterfly. A full pass takes 5*(N/2)*LOG2N cycles from the first RD_A to the last WR_B. busy_o falls in the same cycle done_o rises.
- mem_we_o is 1 only in WR_A/WR_B. mem_addr_o and tw_addr_o are 0 in IDLE.
- The cmac operand outputs hold their last values in IDLE.
- Input data must already be in bit-reversed order in RAM (loader's job). Output is in natural order.
- No stage scaling; overflow on the upper leg wraps as the MAC produces it.

Test Plan:
- LOG2N=3, RAM all 0, start pulse -> busy_o high exactly 60 cycles, done_o single pulse on cycle 61, 24 writes all of value 0, final state IDLE.
- LOG2N=3, impulse: RAM[0]=(16384,0), rest 0 -> every bin (16384,0) within +/-1 LSB.
- LOG2N=3, DC: all RAM=(2048,0) -> bin0=(16384,0), bins 1..7 = 0 within +/-2 LSB.
- Single butterfly, model MAC returning x=(0,0) with A=(30000,-30000) -> lower write (32767,-32768) (saturation both rails).
- start_i held high throughout a pass -> exactly one pass; a new pass begins only if start_i is sampled in IDLE after done_o.
- rstn_i pulsed low in WR_A -> mem_we_o drops to 0 asynchronously in the same cycle; FSM in IDLE; busy_o=0; no done_o; next start runs a full 60-cycle pass.
